filt_cicd_ctrl: RTL and testbench

// Sequencing controller for the CIC decimator datapath (integrators + decimated combs).

---
 rtl/filt_cicd_ctrl_if.sv | 30 +++
 rtl/filt_cicd_ctrl.sv | 168 ++++++++++++++++
 tb/tb_filt_cicd_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/filt_cicd_ctrl_if.sv
// Control/config/strobe bundle between system control and the CIC decimator sequencer.
// No storage; pure wiring, zero latency.
// No backpressure: strobes are fire-and-forget, config errors come back as a pulse.
interface filt_cicd_ctrl_if #(
  parameter int CNT_W = 7
);
  logic             i_ena;
  logic             i_cfg_we;
  logic [CNT_W-1:0] i_cfg_decim;
  logic [CNT_W-1:0] i_cfg_phase;
  logic             o_cfg_err;
  logic             o_clr;
  logic             o_intg_ena;
  logic             o_comb_ena;
  logic             o_oup_vld;
  logic [2:0]       o_state;
  logic             o_busy;

  // System-control side: drives run request and config, observes sequencing outputs.
  modport master (
    output i_ena, i_cfg_we, i_cfg_decim, i_cfg_phase,
    input  o_cfg_err, o_clr, o_intg_ena, o_comb_ena, o_oup_vld, o_state, o_busy
  );

  // Sequencer side.
  modport slave (
    input  i_ena, i_cfg_we, i_cfg_decim, i_cfg_phase,
    output o_cfg_err, o_clr, o_intg_ena, o_comb_ena, o_oup_vld, o_state, o_busy
  );
endinterface

// File: rtl/filt_cicd_ctrl.sv
// Sequencer for the CIC decimator: clear, integrator enable, decimated comb strobe, settled-valid.
// Latency: clear 1 cycle after start, first strobe phase+2 cycles after start, valid P_COMB_LAT after a RUN strobe.
// No backpressure: dropping i_ena returns to IDLE next cycle and flushes pending valid pulses.
module filt_cicd_ctrl #(
  parameter int P_MAX_DECIMATION = 64,
  parameter int P_ORDER          = 3,
  parameter int P_DIFF_DELAY     = 1,
  parameter int P_COMB_LAT       = 1,
  parameter int P_DEF_DECIM      = 8,
  parameter int P_DEF_PHASE      = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_an,
  filt_cicd_ctrl_if.slave  bus
);

  localparam int CNT_W    = $clog2(P_MAX_DECIMATION + 1);
  localparam int SETTLE_N = P_ORDER * P_DIFF_DELAY;
  localparam int SET_W    = $clog2(SETTLE_N + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_decim;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic [SET_W-1:0] r_settle;
  logic             r_cfg_err;

  logic             w_active;
  logic             w_stb;
  logic             w_run_stb;
  logic             w_cfg_ok;
  logic             w_clr;
  logic             w_intg;
  logic             w_settle_done;

  // Datapath is live (integrating, counting) only in SETTLE and RUN.
  assign w_active  = (r_state == ST_SETTLE) || (r_state == ST_RUN);
  assign w_stb     = w_active && (r_cnt == r_phase);
  assign w_run_stb = (r_state == ST_RUN) && w_stb;

  // The strobe that brings the settle count to N*M is the last masked one.
  assign w_settle_done = w_stb && (r_settle == SET_W'(SETTLE_N - 1));

  // A config pair is usable only if the phase lands inside the decimation period.
  assign w_cfg_ok = (bus.i_cfg_decim >= CNT_W'(2)) &&
                    (bus.i_cfg_decim <= CNT_W'(P_MAX_DECIMATION)) &&
                    (bus.i_cfg_phase < bus.i_cfg_decim);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs; a dropped run request wins over every transition.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_intg = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_ena) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_clr  = 1'b1;
        w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_intg = 1'b1;
        if (w_settle_done) w_next = ST_RUN;
      end
      ST_RUN: begin
        w_intg = 1'b1;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (!bus.i_ena) w_next = ST_IDLE;
  end

  // Decimation counter: zeroed by FLUSH, free-runs 0..decim-1 while the datapath is live.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      r_cnt <= '0;
    end else if (w_active) begin
      if (r_cnt == (r_decim - CNT_W'(1))) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Settle counter: counts the masked strobes seen in SETTLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      r_settle <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_settle <= '0;
    end else if ((r_state == ST_SETTLE) && w_stb) begin
      r_settle <= r_settle + SET_W'(1);
    end
  end

  // Config registers: writable only while idle, so a run never sees its timing change.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      r_decim   <= CNT_W'(P_DEF_DECIM);
      r_phase   <= CNT_W'(P_DEF_PHASE);
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (bus.i_cfg_we) begin
        if ((r_state == ST_IDLE) && w_cfg_ok) begin
          r_decim <= bus.i_cfg_decim;
          r_phase <= bus.i_cfg_phase;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
    end
  end

  // Valid pipeline mirrors the comb output register latency.
  generate
    if (P_COMB_LAT == 0) begin : g_nolat
      assign bus.o_oup_vld = w_run_stb;
    end else begin : g_lat
      logic [P_COMB_LAT-1:0] r_vld_sr;
      logic [P_COMB_LAT:0]   w_vld_tap;

      assign w_vld_tap = {r_vld_sr, w_run_stb};

      // Flushed on stop or reset so no stale valid leaks out of an aborted run.
      always_ff @(posedge i_clk) begin
        if (!i_rst_an || !bus.i_ena) begin
          r_vld_sr <= '0;
        end else begin
          r_vld_sr <= w_vld_tap[P_COMB_LAT-1:0];
        end
      end

      assign bus.o_oup_vld = w_vld_tap[P_COMB_LAT];
    end
  endgenerate

  assign bus.o_cfg_err  = r_cfg_err;
  assign bus.o_clr      = w_clr;
  assign bus.o_intg_ena = w_intg;
  assign bus.o_comb_ena = w_stb;
  assign bus.o_state    = r_state;
  assign bus.o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_filt_cicd_ctrl.sv
// Bench for filt_cicd_ctrl: two instances (comb latency 1 and 3) on shared stimulus.
// Expected outputs come from a start-time/arithmetic model, checked every cycle on the falling edge.
// Directed starts pin model timing with literal cycle numbers; a random phase follows.
module tb_filt_cicd_ctrl;

  localparam int NM     = 3;
  localparam int MAXD   = 64;
  localparam int DEF_D  = 8;
  localparam int DEF_P  = 0;

  logic i_clk = 1'b0;
  logic i_rst_an;
  int   cyc = 0;

  logic       s_ena, s_we;
  logic [6:0] s_decim, s_phase;

  int n_vec = 0;
  int n_err = 0;

  filt_cicd_ctrl_if #(.CNT_W(7)) bus_a ();
  filt_cicd_ctrl_if #(.CNT_W(7)) bus_b ();

  assign bus_a.i_ena = s_ena;  assign bus_a.i_cfg_we = s_we;
  assign bus_a.i_cfg_decim = s_decim;  assign bus_a.i_cfg_phase = s_phase;
  assign bus_b.i_ena = s_ena;  assign bus_b.i_cfg_we = s_we;
  assign bus_b.i_cfg_decim = s_decim;  assign bus_b.i_cfg_phase = s_phase;

  filt_cicd_ctrl #(.P_COMB_LAT(1)) dut_a (.i_clk(i_clk), .i_rst_an(i_rst_an), .bus(bus_a));
  filt_cicd_ctrl #(.P_COMB_LAT(3)) dut_b (.i_clk(i_clk), .i_rst_an(i_rst_an), .bus(bus_b));

  initial forever #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit m_active = 0;
  int m_s = 0;
  int m_decim = DEF_D;
  int m_phase = DEF_P;
  bit m_err = 0;
  bit chk_en = 0;
  bit hist_run [64] = '{default: 1'b0};
  bit hist_ok  [64] = '{default: 1'b0};

  // valid(t) = RUN strobe L cycles ago, provided no stop/reset edge since it was captured
  function automatic bit exp_vld(int t, int lat, bit run_now);
    if (lat == 0) return run_now;
    if (t < lat) return 1'b0;
    if (!hist_run[(t - lat) % 64]) return 1'b0;
    for (int k = t - lat; k < t; k++)
      if (!hist_ok[k % 64]) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge i_clk) begin : model
    int t, j, tnm, st;
    bit clr, intg, comb, run_now, legal, va, vb;
    t = cyc; st = 0; clr = 0; intg = 0; comb = 0; run_now = 0;
    if (m_active) begin
      if (t == m_s + 1) begin
        st = 1; clr = 1;
      end else if (t >= m_s + 2) begin
        j    = t - m_s - 2;
        tnm  = m_phase + (NM - 1) * m_decim;   // cycle index of the last masked strobe
        intg = 1;
        comb = ((j % m_decim) == m_phase);
        st   = (j <= tnm) ? 2 : 3;
        run_now = comb && (j > tnm);
      end
    end
    hist_run[t % 64] = run_now;
    va = exp_vld(t, 1, run_now);
    vb = exp_vld(t, 3, run_now);
    if (chk_en) begin
      chk("a_state", bus_a.o_state, st);     chk("b_state", bus_b.o_state, st);
      chk("a_busy",  bus_a.o_busy, st != 0); chk("b_busy",  bus_b.o_busy, st != 0);
      chk("a_clr",   bus_a.o_clr, clr);      chk("b_clr",   bus_b.o_clr, clr);
      chk("a_intg",  bus_a.o_intg_ena, intg); chk("b_intg", bus_b.o_intg_ena, intg);
      chk("a_comb",  bus_a.o_comb_ena, comb); chk("b_comb", bus_b.o_comb_ena, comb);
      chk("a_err",   bus_a.o_cfg_err, m_err); chk("b_err",  bus_b.o_cfg_err, m_err);
      chk("a_vld",   bus_a.o_oup_vld, va);   chk("b_vld",   bus_b.o_oup_vld, vb);
    end
    // advance model with the inputs the coming rising edge will sample
    hist_ok[t % 64] = s_ena && i_rst_an;
    m_err = 0;
    if (!i_rst_an) begin
      m_active = 0; m_decim = DEF_D; m_phase = DEF_P; chk_en = 1;
    end else begin
      if (s_we) begin
        legal = (s_decim >= 2) && (s_decim <= MAXD) && (s_phase < s_decim);
        if (!m_active && legal) begin
          m_decim = int'(s_decim); m_phase = int'(s_phase);
        end else begin
          m_err = 1;
        end
      end
      if (!s_ena) m_active = 0;
      else if (!m_active) begin m_active = 1; m_s = t; end
    end
  end

  // ---------------- stimulus ----------------
  int c, fc, fs, fv, fvb, fvb2;

  task automatic capture(input int ncyc);
    fc = -1; fs = -1; fv = -1; fvb = -1; fvb2 = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge i_clk);
      if (bus_a.o_clr === 1'b1 && fc < 0) fc = cyc;
      if (bus_a.o_comb_ena === 1'b1 && fs < 0) fs = cyc;
      if (bus_a.o_oup_vld === 1'b1 && fv < 0) fv = cyc;
      if (bus_b.o_oup_vld === 1'b1) begin
        if (fvb < 0) fvb = cyc;
        else if (fvb2 < 0) fvb2 = cyc;
      end
    end
  endtask

  task automatic cfg_write(input int d, input int p);
    s_we = 1; s_decim = 7'(d); s_phase = 7'(p);
    step();
    s_we = 0;
  endtask

  initial begin
    i_rst_an = 0; s_ena = 0; s_we = 0; s_decim = '0; s_phase = '0;
    repeat (3) step();
    i_rst_an = 1;
    repeat (2) step();

    // defaults: decim 8, phase 0
    c = cyc; s_ena = 1;
    capture(60);
    chk("t1_clr_cycle",   fc,  c + 1);
    chk("t1_first_strobe", fs, c + 2);
    chk("t1_first_vld_a", fv,  c + 27);
    chk("t1_first_vld_b", fvb, c + 29);
    chk("t1_second_vld_b", fvb2, c + 37);

    // decim 5, phase 3
    step(); s_ena = 0; step();
    cfg_write(5, 3);
    c = cyc; s_ena = 1;
    capture(50);
    chk("t2_first_strobe", fs, c + 5);
    chk("t2_first_vld_a",  fv, c + 21);

    // decim 2, phase 0 with write coinciding with the start
    step(); s_ena = 0; step();
    c = cyc; s_ena = 1; s_we = 1; s_decim = 7'd2; s_phase = 7'd0;
    step(); s_we = 0;
    capture(30);
    chk("t6_first_vld_a",  fv,   c + 9);
    chk("t6_first_vld_b",  fvb,  c + 11);
    chk("t6_second_vld_b", fvb2, c + 13);

    // legal values written during RUN are refused
    step();
    cfg_write(6, 1);
    @(negedge i_clk);
    chk("t3_run_write_err", bus_a.o_cfg_err, 1'b1);
    step();
    // illegal values written while idle
    s_ena = 0; step(); step();
    cfg_write(1, 0);
    cfg_write(65, 0);
    cfg_write(4, 4);
    s_ena = 1;
    repeat (40) step();
    // stop one cycle before a RUN strobe, then restart
    s_ena = 0; step(); s_ena = 1;
    repeat (20) step();

    // random phase: stops, restarts, resets mid-run, config writes in all states
    for (int k = 0; k < 4000; k++) begin
      i_rst_an = ($urandom_range(0, 399) != 0);
      if (s_ena) begin
        if ($urandom_range(0, 249) == 0) s_ena = 0;
      end else if ($urandom_range(0, 14) == 0) begin
        s_ena = 1;
      end
      if ($urandom_range(0, s_ena ? 39 : 3) == 0) begin
        s_we = 1;
        if ($urandom_range(0, 9) < 7) s_decim = 7'($urandom_range(2, 12));
        else                          s_decim = 7'($urandom_range(0, 70));
        s_phase = 7'($urandom_range(0, int'(s_decim) + 1));
      end else begin
        s_we = 0;
      end
      step();
    end
    i_rst_an = 1; s_we = 0; s_ena = 0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
